uart_rx: RTL

UART receive front end. Samples the asynchronous serial line with an internal 16x oversampling baud tick, validates start, data, parity and stop bits, and deframes each character. It sits directly upstream of the UART receive FIFO. rx_data drives the FIFO w_data, and rx_done_tick drives the FIFO wr_en.

---
 rtl/uart_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with start/parity/stop checking and deframing
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int DVSR       = 27,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_done_tick,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  rx_busy
);
  localparam int SMAX = SB_TICK > 16 ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int BW   = $clog2(DVSR);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] b_q, b_d, data_q, data_d;
  logic                  p_q, p_d, done_q, done_d, ferr_q, ferr_d, perr_q, perr_d, busy_q, busy_d;
  logic                  rx_s, tick;
  assign rx_s = sync_q[1];
  assign tick = baud_q == BW'(DVSR - 1);
  assign rx_data      = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;
  assign rx_busy      = busy_q;
  // next-state: synchronizer shift, free-running baud divider and the deframing FSM
  always_comb begin
    sync_d  = {sync_q[0], rx};
    baud_d  = tick ? '0 : baud_q + BW'(1);
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (tick) begin
        if (s_q == SW'(7)) begin
          state_d = rx_s ? IDLE : DATA;
          s_d     = '0;
          n_d     = '0;
        end else s_d = s_q + SW'(1);
      end
      DATA: if (tick) begin
        if (s_q == SW'(15)) begin
          b_d = {rx_s, b_q[DATA_WIDTH-1:1]};
          s_d = '0;
          if (n_q == NW'(DATA_WIDTH - 1)) state_d = PARITY_EN != 0 ? PARITY : STOP;
          else n_d = n_q + NW'(1);
        end else s_d = s_q + SW'(1);
      end
      PARITY: if (tick) begin
        if (s_q == SW'(15)) begin
          p_d     = rx_s;
          s_d     = '0;
          state_d = STOP;
        end else s_d = s_q + SW'(1);
      end
      STOP: if (tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          state_d = rx_s ? IDLE : BRK;
          ferr_d  = !rx_s;
          perr_d  = rx_s && (PARITY_EN != 0) && (^b_q ^ p_q ^ 1'(PARITY_ODD));
          done_d  = rx_s && !perr_d;
          data_d  = done_d ? b_q : data_q;
        end else s_d = s_q + SW'(1);
      end
      BRK: state_d = rx_s ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // register all state and outputs; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      baud_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      baud_q  <= baud_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end
endmodule
